// File: rtl/cpu_pkg.sv
// Shared CPU encodings used by the writeback stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Writeback source select (3 is reserved and behaves as WB_ALU)
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  // Load type (5..7 behave as LD_W)
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

endpackage

// File: rtl/load_align.sv
// Big-endian load formatter: extracts byte/halfword from an aligned word,
// extends it, and flags misaligned word/halfword accesses.
module load_align
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_ld_type,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_misalign
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Lane select: offset 0 is the most significant lane
  always_comb begin
    w_half = i_addr_lo[1] ? i_mem_data[15:0] : i_mem_data[31:16];
    unique case (i_addr_lo)
      2'd0:    w_byte = i_mem_data[31:24];
      2'd1:    w_byte = i_mem_data[23:16];
      2'd2:    w_byte = i_mem_data[15:8];
      default: w_byte = i_mem_data[7:0];
    endcase
  end

  // Extension and alignment check by load type
  always_comb begin
    o_ld_data  = i_mem_data;
    o_misalign = (i_addr_lo != 2'd0);
    case (i_ld_type)
      LD_H: begin
        o_ld_data  = {{16{w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      LD_HU: begin
        o_ld_data  = {16'h0000, w_half};
        o_misalign = i_addr_lo[0];
      end
      LD_B: begin
        o_ld_data  = {{24{w_byte[7]}}, w_byte};
        o_misalign = 1'b0;
      end
      LD_BU: begin
        o_ld_data  = {24'h000000, w_byte};
        o_misalign = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load formatting, writeback mux,
// same-cycle write-to-read bypass and retired-instruction counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_RegWrite,
  input  logic [4:0]       m_WN,
  input  logic [1:0]       m_WbSel,
  input  logic [2:0]       m_LdType,
  input  logic [XLEN-1:0]  m_ALUOut,
  input  logic [XLEN-1:0]  m_MemData,
  input  logic [XLEN-1:0]  m_PC4,
  output logic             RegWrite,
  output logic [4:0]       WN,
  output logic [XLEN-1:0]  WD,
  input  logic [4:0]       RN1,
  input  logic [4:0]       RN2,
  input  logic [XLEN-1:0]  RF_RD1,
  input  logic [XLEN-1:0]  RF_RD2,
  output logic [XLEN-1:0]  RD1,
  output logic [XLEN-1:0]  RD2,
  output logic             misalign,
  output logic [CNT_W-1:0] retire_cnt
);

  // MEM/WB pipeline register fields
  logic            w_valid;
  logic            w_RegWrite;
  logic [4:0]      w_WN;
  logic [1:0]      w_WbSel;
  logic [2:0]      w_LdType;
  logic [XLEN-1:0] w_ALUOut;
  logic [XLEN-1:0] w_MemData;
  logic [XLEN-1:0] w_PC4;

  logic [CNT_W-1:0] r_retire_cnt;
  logic [XLEN-1:0]  w_ld_data;
  logic             w_ld_misalign;

  // MEM/WB register: flush beats stall; flushed fields other than valid just hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid    <= 1'b0;
      w_RegWrite <= 1'b0;
      w_WN       <= '0;
      w_WbSel    <= '0;
      w_LdType   <= '0;
      w_ALUOut   <= '0;
      w_MemData  <= '0;
      w_PC4      <= '0;
    end else if (flush) begin
      w_valid <= 1'b0;
    end else if (!stall) begin
      w_valid    <= m_valid;
      w_RegWrite <= m_RegWrite;
      w_WN       <= m_WN;
      w_WbSel    <= m_WbSel;
      w_LdType   <= m_LdType;
      w_ALUOut   <= m_ALUOut;
      w_MemData  <= m_MemData;
      w_PC4      <= m_PC4;
    end
  end

  // Retire counter: an instruction retires when it leaves WB unstalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_valid && !stall) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  load_align u_load_align (
    .i_mem_data (w_MemData),
    .i_addr_lo  (w_ALUOut[1:0]),
    .i_ld_type  (w_LdType),
    .o_ld_data  (w_ld_data),
    .o_misalign (w_ld_misalign)
  );

  // Writeback mux, write enable and decode-read bypass
  always_comb begin
    misalign = w_valid && (w_WbSel == WB_LOAD) && w_ld_misalign;
    case (w_WbSel)
      WB_LOAD: WD = w_ld_data;
      WB_LINK: WD = w_PC4 + 32'd4;
      default: WD = w_ALUOut;
    endcase
    // Register 0 never written, so bypass never fires for RN==0
    RegWrite = w_valid && w_RegWrite && (w_WN != 5'd0) && !misalign;
    WN       = w_WN;
    RD1      = (RegWrite && (RN1 == w_WN)) ? WD : RF_RD1;
    RD2      = (RegWrite && (RN2 == w_WN)) ? WD : RF_RD2;
  end

  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic        m_RegWrite;
  logic [4:0]  m_WN;
  logic [1:0]  m_WbSel;
  logic [2:0]  m_LdType;
  logic [31:0] m_ALUOut;
  logic [31:0] m_MemData;
  logic [31:0] m_PC4;
  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic [4:0]  RN1;
  logic [4:0]  RN2;
  logic [31:0] RF_RD1;
  logic [31:0] RF_RD2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        misalign;
  logic [31:0] retire_cnt;

  int n_checks;
  int n_fail;
  // Reference model of the WB valid bit and retire count
  logic        mdl_valid;
  logic [31:0] exp_cnt;

  wb_stage #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_RegWrite (m_RegWrite),
    .m_WN       (m_WN),
    .m_WbSel    (m_WbSel),
    .m_LdType   (m_LdType),
    .m_ALUOut   (m_ALUOut),
    .m_MemData  (m_MemData),
    .m_PC4      (m_PC4),
    .RegWrite   (RegWrite),
    .WN         (WN),
    .WD         (WD),
    .RN1        (RN1),
    .RN2        (RN2),
    .RF_RD1     (RF_RD1),
    .RF_RD2     (RF_RD2),
    .RD1        (RD1),
    .RD2        (RD2),
    .misalign   (misalign),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [4:0] wn,
                         input logic [1:0] sel, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4);
    m_valid = v; m_RegWrite = rw; m_WN = wn; m_WbSel = sel; m_LdType = lt;
    m_ALUOut = alu; m_MemData = mem; m_PC4 = pc4;
  endtask

  // One clock edge; model tracks retire count, outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    if (mdl_valid && !stall) exp_cnt = exp_cnt + 1;
    if (flush) mdl_valid = 1'b0;
    else if (!stall) mdl_valid = m_valid;
    #1;
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  a;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[10] = '{
    '{3'd3, 2'd0, 32'hFFFFFF80},  // lb  @0
    '{3'd4, 2'd0, 32'h00000080},  // lbu @0
    '{3'd1, 2'd2, 32'h00007F01},  // lh  @2
    '{3'd2, 2'd0, 32'h000080FF},  // lhu @0
    '{3'd1, 2'd0, 32'hFFFF80FF},  // lh  @0
    '{3'd3, 2'd1, 32'hFFFFFFFF},  // lb  @1
    '{3'd4, 2'd2, 32'h0000007F},  // lbu @2
    '{3'd3, 2'd3, 32'h00000001},  // lb  @3
    '{3'd0, 2'd0, 32'h80FF7F01},  // lw  @0
    '{3'd6, 2'd0, 32'h80FF7F01}   // type 6 acts as lw
  };

  initial begin
    n_checks = 0; n_fail = 0;
    mdl_valid = 1'b0; exp_cnt = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_mem(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    RN1 = 5'd0; RN2 = 5'd3; RF_RD1 = 32'hAAAA; RF_RD2 = 32'hBBBB;

    // Reset state
    #12;
    check_eq("rst_regwrite", RegWrite, 1'b0);
    check_eq("rst_wn", WN, 5'd0);
    check_eq("rst_wd", WD, 32'h0);
    check_eq("rst_misalign", misalign, 1'b0);
    check_eq("rst_cnt", retire_cnt, 32'd0);
    check_eq("rst_rd1", RD1, 32'hAAAA);
    check_eq("rst_rd2", RD2, 32'hBBBB);
    rst_n = 1'b1;

    // ALU writeback
    set_mem(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
    step();
    check_eq("alu_regwrite", RegWrite, 1'b1);
    check_eq("alu_wn", WN, 5'd5);
    check_eq("alu_wd", WD, 32'h1234);
    check_eq("alu_cnt0", retire_cnt, 32'd0);
    set_mem(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    check_eq("alu_cnt1", retire_cnt, 32'd1);
    check_eq("bubble_regwrite", RegWrite, 1'b0);

    // Load formatting
    foreach (ld_tab[i]) begin
      set_mem(1'b1, 1'b1, 5'd3, 2'd1, ld_tab[i].lt, {30'h0, ld_tab[i].a}, 32'h80FF7F01,
              32'h0);
      step();
      check_eq($sformatf("load%0d_wd", i), WD, ld_tab[i].exp);
      check_eq($sformatf("load%0d_we", i), RegWrite, 1'b1);
      check_eq($sformatf("load%0d_mis", i), misalign, 1'b0);
    end
    check_eq("load_cnt", retire_cnt, exp_cnt);

    // Misaligned lw and lh: write suppressed, still retired
    set_mem(1'b1, 1'b1, 5'd4, 2'd1, 3'd0, 32'h102, 32'h1, 32'h0);
    step();
    check_eq("lw_mis", misalign, 1'b1);
    check_eq("lw_mis_we", RegWrite, 1'b0);
    set_mem(1'b1, 1'b1, 5'd4, 2'd1, 3'd2, 32'h101, 32'h1, 32'h0);
    step();
    check_eq("lhu_mis", misalign, 1'b1);
    check_eq("lhu_mis_we", RegWrite, 1'b0);
    check_eq("lw_mis_cnt", retire_cnt, exp_cnt);
    // Low address bits on an ALU op are not a misalignment
    set_mem(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 32'h3, 32'h0, 32'h0);
    step();
    check_eq("alu_lowbits_mis", misalign, 1'b0);
    check_eq("alu_lowbits_we", RegWrite, 1'b1);
    check_eq("mis_retired_cnt", retire_cnt, exp_cnt);

    // Write to $zero suppressed; RN1=0 passes raw value
    set_mem(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h5555, 32'h0, 32'h0);
    RN1 = 5'd0; RF_RD1 = 32'h1357;
    step();
    check_eq("zero_we", RegWrite, 1'b0);
    check_eq("zero_rd1", RD1, 32'h1357);

    // Bypass
    set_mem(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'hDEAD, 32'h0, 32'h0);
    RN1 = 5'd7; RF_RD1 = 32'h1111; RN2 = 5'd8; RF_RD2 = 32'h2222;
    step();
    check_eq("byp_rd1", RD1, 32'hDEAD);
    check_eq("byp_rd2_raw", RD2, 32'h2222);
    RN2 = 5'd7; #1;
    check_eq("byp_rd2", RD2, 32'hDEAD);
    RN2 = 5'd8;

    // Link, including 32-bit wrap
    set_mem(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFFFFFC);
    step();
    check_eq("link_wrap_wd", WD, 32'h0);
    set_mem(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h77, 32'h0, 32'h400);
    step();
    check_eq("link_wd", WD, 32'h404);
    check_eq("link_wn", WN, 5'd31);

    // Stall holds outputs and freezes the counter
    set_mem(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h9999, 32'h0, 32'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("stall%0d_wd", k), WD, 32'h404);
      check_eq($sformatf("stall%0d_we", k), RegWrite, 1'b1);
      check_eq($sformatf("stall%0d_cnt", k), retire_cnt, exp_cnt);
    end
    stall = 1'b0;
    step();
    check_eq("unstall_wd", WD, 32'h9999);
    check_eq("unstall_cnt", retire_cnt, exp_cnt);

    // Flush with stall: bubble, no retire
    flush = 1'b1; stall = 1'b1;
    step();
    check_eq("flush_stall_we", RegWrite, 1'b0);
    check_eq("flush_stall_cnt", retire_cnt, exp_cnt);
    // Flush alone of a valid instruction retires it
    flush = 1'b0; stall = 1'b0;
    step();
    flush = 1'b1;
    step();
    check_eq("flush_we", RegWrite, 1'b0);
    check_eq("flush_cnt", retire_cnt, exp_cnt);
    flush = 1'b0;

    // Reset mid-operation discards the in-flight load
    set_mem(1'b1, 1'b1, 5'd6, 2'd1, 3'd0, 32'h0, 32'hCAFEF00D, 32'h0);
    step();
    check_eq("pre_rst_we", RegWrite, 1'b1);
    check_eq("pre_rst_wd", WD, 32'hCAFEF00D);
    set_mem(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    mdl_valid = 1'b0; exp_cnt = 0;
    #1;
    check_eq("mid_rst_we", RegWrite, 1'b0);
    check_eq("mid_rst_cnt", retire_cnt, 32'd0);
    check_eq("mid_rst_wd", WD, 32'h0);
    #3;
    rst_n = 1'b1;
    step();
    step();
    check_eq("post_rst_cnt", retire_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
